// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: mode encoding, FSM states and
// CPOL/CPHA extraction.
package spi_pkg;

  // {CPOL, CPHA}
  typedef enum logic [1:0] {
    MODE_POL_PHS_00 = 2'b00,
    MODE_POL_PHS_01 = 2'b01,
    MODE_POL_PHS_10 = 2'b10,
    MODE_POL_PHS_11 = 2'b11
  } spi_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StLead,
    StXfer,
    StTrail
  } spi_state_e;

  function automatic logic cpol(input spi_mode_e mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input spi_mode_e mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing engine: half-bit counter, SCLK edge counter and the SCLK register.
// Produces a half-bit tick for the lead/trail phases and leading/trailing edge
// strobes plus a done flag for the transfer phase.
module spi_sclk_gen #(
  parameter int unsigned WORD_LENGTH      = 8,
  parameter int unsigned CLK_PER_HALF_BIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,        // half-bit counter active (lead, transfer, trail)
  input  logic toggle_en,  // transfer phase: SCLK edges are generated
  input  logic load,       // force SCLK to its idle level
  input  logic load_val,
  output logic sclk,
  output logic half_tick,  // last clk cycle of a half-bit period
  output logic lead_edge,  // this clk edge produces an odd-numbered SCLK edge
  output logic trail_edge, // this clk edge produces an even-numbered SCLK edge
  output logic done        // this clk edge produces the final SCLK edge
);

  localparam int unsigned HalfW = (CLK_PER_HALF_BIT > 1) ? $clog2(CLK_PER_HALF_BIT) : 1;
  localparam int unsigned EdgeW = $clog2(2 * WORD_LENGTH + 1);
  localparam logic [HalfW-1:0] HalfMax  = HalfW'(CLK_PER_HALF_BIT - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * WORD_LENGTH - 1);

  logic [HalfW-1:0] half_cnt_q;
  logic [EdgeW-1:0] edge_cnt_q;
  logic             sclk_q;
  logic             xfer_tick;

  assign half_tick  = run && (half_cnt_q == HalfMax);
  assign xfer_tick  = half_tick && toggle_en;
  assign lead_edge  = xfer_tick && !edge_cnt_q[0];
  assign trail_edge = xfer_tick && edge_cnt_q[0];
  assign done       = trail_edge && (edge_cnt_q == EdgeLast);
  assign sclk       = sclk_q;

  // Half-bit counter: wraps every H cycles while running, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_q <= '0;
    end else if (!run || half_tick) begin
      half_cnt_q <= '0;
    end else begin
      half_cnt_q <= half_cnt_q + 1'b1;
    end
  end

  // SCLK edge counter: counts edges within a transfer, wraps to 0 on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
    end else if (!toggle_en) begin
      edge_cnt_q <= '0;
    end else if (xfer_tick) begin
      edge_cnt_q <= done ? '0 : edge_cnt_q + 1'b1;
    end
  end

  // SCLK register: loaded with CPOL at acceptance, toggled on every edge tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
    end else if (load) begin
      sclk_q <= load_val;
    end else if (xfer_tick) begin
      sclk_q <= ~sclk_q;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Full-duplex single-word SPI master with per-transfer CPOL/CPHA, one-hot
// active-low slave selects and a ready/busy handshake.
// Optional build macro SPI_LSB_FIRST_EN adds the lsb_first input (LSB-first
// shifting in both directions); without it every transfer is MSB first.
module spi_master_cfg #(
  parameter int unsigned WORD_LENGTH      = 8,
  parameter int unsigned CLK_PER_HALF_BIT = 2,
  parameter int unsigned NUM_SS           = 4,
  localparam int unsigned SsW             = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_valid,
  input  logic [WORD_LENGTH-1:0] WDATA,
  input  logic [1:0]             spi_mode,
  input  logic [SsW-1:0]         ss_sel,
`ifdef SPI_LSB_FIRST_EN
  input  logic                   lsb_first,
`endif
  output logic [WORD_LENGTH-1:0] RDATA,
  output logic                   rdata_valid,
  output logic                   SPI_status_RDY_BSYbar,
  output logic                   SCLK,
  output logic                   MOSI,
  input  logic                   MISO,
  output logic [NUM_SS-1:0]      SSbar
);

  import spi_pkg::*;

  spi_state_e            state_q;
  spi_mode_e             mode_q;
  logic [SsW-1:0]        ss_q;
  logic [WORD_LENGTH-1:0] shreg_q;
  logic [WORD_LENGTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  ready_q;
  logic                  mosi_q;
  logic [NUM_SS-1:0]     ssbar_q;

  logic                  accept;
  logic                  half_tick, lead_edge, trail_edge, done;
  logic                  sample, drive;
  logic                  lsb_mode;
  logic                  tx_bit;
  logic [WORD_LENGTH-1:0] shifted;
  logic [NUM_SS-1:0]     ss_dec;

  assign accept = (state_q == StIdle) && data_valid;

`ifdef SPI_LSB_FIRST_EN
  logic lsb_mode_q;

  // Bit order is captured with the rest of the transfer configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsb_mode_q <= 1'b0;
    end else if (accept) begin
      lsb_mode_q <= lsb_first;
    end
  end

  assign lsb_mode = lsb_mode_q;
`else
  assign lsb_mode = 1'b0;
`endif

  spi_sclk_gen #(
    .WORD_LENGTH     (WORD_LENGTH),
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       ((state_q == StLead) || (state_q == StXfer) || (state_q == StTrail)),
    .toggle_en (state_q == StXfer),
    .load      (accept),
    .load_val  (spi_mode[1]),
    .sclk      (SCLK),
    .half_tick (half_tick),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .done      (done)
  );

  // Data path selection: which edge samples, which drives, and the bit order.
  always_comb begin
    sample = cpha(mode_q) ? trail_edge : lead_edge;
    // With CPHA=0 the final trailing edge ends the word without a new MOSI bit.
    drive  = cpha(mode_q) ? lead_edge : (trail_edge && !done);
    if (lsb_mode) begin
      tx_bit  = shreg_q[0];
      shifted = {MISO, shreg_q[WORD_LENGTH-1:1]};
    end else begin
      tx_bit  = shreg_q[WORD_LENGTH-1];
      shifted = {shreg_q[WORD_LENGTH-2:0], MISO};
    end
  end

  // Slave-select decode; an out-of-range index leaves every select inactive.
  always_comb begin
    ss_dec = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (32'(ss_q) == i) begin
        ss_dec[i] = 1'b0;
      end
    end
  end

  // Transfer FSM with shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode_q   <= MODE_POL_PHS_00;
      ss_q     <= '0;
      shreg_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      mosi_q   <= 1'b0;
      ssbar_q  <= '1;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (data_valid) begin
            mode_q  <= spi_mode_e'(spi_mode);
            ss_q    <= ss_sel;
            shreg_q <= WDATA;
            ready_q <= 1'b0;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          if (!cpha(mode_q)) begin
            mosi_q <= tx_bit;
          end
          ssbar_q <= ss_dec;
          state_q <= StLead;
        end
        StLead: begin
          if (half_tick) begin
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (sample) begin
            shreg_q <= shifted;
          end
          if (drive) begin
            mosi_q <= tx_bit;
          end
          if (done) begin
            state_q <= StTrail;
          end
        end
        StTrail: begin
          if (half_tick) begin
            ssbar_q  <= '1;
            rdata_q  <= shreg_q;
            rvalid_q <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign RDATA                 = rdata_q;
  assign rdata_valid           = rvalid_q;
  assign SPI_status_RDY_BSYbar = ready_q;
  assign MOSI                  = mosi_q;
  assign SSbar                 = ssbar_q;

endmodule
